sha256_padder: RTL and testbench

Streaming message padder that feeds the `sha256` core. It accepts raw message bytes one per cycle and assembles them MSB-first into a `MAX_CHUNKS*512`-bit buffer. It then appends the SHA-256 padding: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. The result is presented as `str` plus `num_chunks`, held stable until the consumer acknowledges it. `out_valid` drives the core's `start`; `out_ack` is pulsed by the controller after the core's `done`.

---
 rtl/sha256_padder.sv | 108 ++++++++++
 tb/tb_sha256_padder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: collects bytes MSB-first, then appends 0x80, zero fill
// and the 64-bit big-endian bit length; holds the block until acknowledged.
module sha256_padder #(
  parameter int MAX_CHUNKS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_keep,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [MAX_CHUNKS*512-1:0]     str,
  output logic [$clog2(MAX_CHUNKS):0]   num_chunks,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic                          err
);
  localparam int NB    = MAX_CHUNKS * 64;
  localparam int L_MAX = NB - 9;
  localparam int CW    = $clog2(NB);
  localparam int NCW   = $clog2(MAX_CHUNKS) + 1;
  localparam logic [CW-1:0] L_MAX_C = CW'(L_MAX);

  typedef enum logic [1:0] {LOAD, PAD, HOLD, DRAIN} state_t;

  state_t               state;
  logic [NB-1:0][7:0]   data;   // data[NB-1] is byte index 0
  logic [CW-1:0]        count;
  logic [NCW-1:0]       pad_nc;
  logic [63:0]          len_bits;
  int                   len_base;

  always_comb begin
    pad_nc   = NCW'((32'(count) + 32'd8) / 32'd64 + 32'd1);
    len_bits = 64'(count) << 3;
    len_base = int'(pad_nc) * 64 - 8;
  end

  assign str = data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      data       <= '0;
      count      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      num_chunks <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (in_keep && count == L_MAX_C) begin
              // Oversize: a final beat errors at once, otherwise swallow the rest.
              if (in_last) begin
                err   <= 1'b1;
                data  <= '0;
                count <= '0;
              end else begin
                state <= DRAIN;
              end
            end else begin
              if (in_keep) begin
                data[CW'(NB-1) - count] <= in_data;
                count <= count + CW'(1);
              end
              if (in_last) begin
                state    <= PAD;
                in_ready <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          // Buffer was cleared on entry to LOAD, so only marker and length are written.
          data[CW'(NB-1) - count] <= 8'h80;
          for (int k = 0; k < 8; k++)
            data[CW'(NB - 1 - len_base - k)] <= len_bits[63-8*k -: 8];
          num_chunks <= pad_nc;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ack) begin
            data       <= '0;
            count      <= '0;
            num_chunks <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            state      <= LOAD;
          end
        end
        DRAIN: begin
          if (in_valid && in_last) begin
            err   <= 1'b1;
            data  <= '0;
            count <= '0;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: stimulus pushes expected blocks, a monitor
// pops and compares on each rising out_valid.
module tb_sha256_padder;
  localparam int MC = 2;
  localparam int W  = MC * 512;
  localparam int NB = MC * 64;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_keep, in_last, out_ack;
  logic [7:0]   in_data;
  logic         in_ready, out_valid, err;
  logic [W-1:0] str;
  logic [1:0]   num_chunks;

  sha256_padder #(.MAX_CHUNKS(MC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last), .in_ready(in_ready), .str(str),
    .num_chunks(num_chunks), .out_valid(out_valid), .out_ack(out_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic [1:0]   nc;
  } exp_t;

  localparam exp_t ABC = '{s: {32'h61626380, 416'h0, 64'h18, 512'h0}, nc: 2'd1};

  exp_t       q[$];
  int         n_cmp = 0, n_bad = 0, err_seen = 0;
  logic [7:0] mb[256];
  int         ml;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      for (int i = 0; i < NB; i++)
        if (got[W-1-8*i -: 8] !== exp[W-1-8*i -: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", name, i,
                   got[W-1-8*i -: 8], exp[W-1-8*i -: 8]);
          break;
        end
    end
  endtask

  function automatic exp_t model(input int n);
    logic [7:0]  p[NB];
    exp_t        e;
    int          nc;
    logic [63:0] len;
    for (int i = 0; i < NB; i++) p[i] = 8'h00;
    for (int i = 0; i < n; i++) p[i] = mb[i];
    p[n] = 8'h80;
    nc   = (n + 8) / 64 + 1;
    len  = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) p[nc*64-1-k] = len[8*k +: 8];
    e.s = '0;
    for (int i = 0; i < NB; i++) e.s[W-1-8*i -: 8] = p[i];
    e.nc = 2'(nc);
    return e;
  endfunction

  // Monitor: compare on every rising out_valid, count err pulses.
  logic ov_q = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (err) err_seen++;
    if (out_valid && !ov_q) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: out_valid rose with nothing expected");
      end else begin
        e = q.pop_front();
        chk("num_chunks", 64'(num_chunks), 64'(e.nc));
        chk_str("str", str, e.s);
      end
    end
    ov_q = out_valid;
  end

  task automatic fill(input int n);
    ml = n;
    for (int i = 0; i < n; i++) mb[i] = 8'(i * 13 + 5);
  endtask

  task automatic set_abc();
    ml = 3; mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63;
  endtask

  // Sends mb[0..ml-1]; an empty message is a single keep=0/last=1 beat.
  task automatic send(input bit with_last);
    int i = 0, guard = 0;
    int nbeats = (ml == 0) ? 1 : ml;
    while (i < nbeats && guard < 1000) begin
      in_valid = 1'b1;
      in_keep  = (ml != 0);
      in_data  = (ml != 0) ? mb[i] : 8'h00;
      in_last  = with_last && (i == nbeats - 1);
      if (in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    if (i < nbeats) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: sent %0d of %0d beats", i, nbeats);
    end
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    int g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk("ack_out_valid", 64'(out_valid), 64'd0);
    chk("ack_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lens[4]  = '{55, 56, 80, 119};
    int          hnc[4]   = '{1, 2, 2, 2};
    logic [63:0] hlen[4]  = '{64'h1B8, 64'h1C0, 64'h280, 64'h3B8};
    int          hold_bad;
    exp_t        e56;

    reset = 1'b1; in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_num_chunks", 64'(num_chunks), 64'd0);
    chk("rst_str_zero", 64'(|str), 64'd0);
    reset = 1'b0;

    // "abc" with latency check
    set_abc(); q.push_back(ABC); send(1'b1);
    chk("abc_lat_edge_n", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("abc_lat_edge_n1", 64'(out_valid), 64'd1);
    ack();

    // empty message
    ml = 0; q.push_back(model(0)); send(1'b1); wait_out();
    chk("empty_byte0", 64'(str[W-1 -: 8]), 64'h80);
    ack();

    // length boundaries with hand-known fields
    for (int t = 0; t < 4; t++) begin
      fill(lens[t]); q.push_back(model(lens[t])); send(1'b1); wait_out();
      chk("bnd_num_chunks", 64'(num_chunks), 64'(hnc[t]));
      chk("bnd_marker", 64'(str[W-1-8*lens[t] -: 8]), 64'h80);
      chk("bnd_len_field", (hnc[t] == 1) ? str[575:512] : str[63:0], hlen[t]);
      ack();
    end

    // hold for 20 cycles with input pressure, then back-to-back message
    fill(56); e56 = model(56); q.push_back(e56); send(1'b1); wait_out();
    hold_bad = 0;
    in_valid = 1'b1; in_keep = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) hold_bad++;
    end
    in_valid = 1'b0; in_keep = 1'b0;
    chk("hold_in_ready_low_cycles", 64'(hold_bad), 64'd0);
    chk_str("hold_str_stable", str, e56.s);
    ack();
    set_abc(); q.push_back(ABC); send(1'b1); wait_out(); ack();

    // 121 bytes: overflow at byte 120, drain to last
    fill(121); send(1'b1);
    chk("ovf_drain_err", 64'(err), 64'd1);
    @(posedge clk); #1;
    chk("ovf_drain_err_one_cycle", 64'(err), 64'd0);
    repeat (5) @(posedge clk); #1;
    chk("ovf_no_out_valid", 64'(out_valid), 64'd0);
    set_abc(); q.push_back(ABC); send(1'b1); wait_out(); ack();

    // 120 bytes with last on the overflowing beat
    fill(120); send(1'b1);
    chk("ovf_last_err", 64'(err), 64'd1);
    chk("ovf_last_in_ready", 64'(in_ready), 64'd1);
    set_abc(); q.push_back(ABC); send(1'b1); wait_out(); ack();

    // reset after 10 bytes
    fill(10); send(1'b0);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_str_zero", 64'(|str), 64'd0);
    set_abc(); q.push_back(ABC); send(1'b1); wait_out(); ack();

    // reset during HOLD
    set_abc(); q.push_back(ABC); send(1'b1); wait_out();
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    chk("holdrst_out_valid", 64'(out_valid), 64'd0);
    chk("holdrst_num_chunks", 64'(num_chunks), 64'd0);

    repeat (4) @(posedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("err_pulse_total", 64'(err_seen), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
